// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and tx FIFO write-port bundle for uart_tx_arbiter
//
// Purpose: groups the NREQ byte-stream requester handshakes and the tx FIFO
// write side into one bundle.
//   req_valid   [NREQ]    requester i offers req_data[8i+7:8i]
//   req_data    [8*NREQ]  packed request bytes
//   req_last    [NREQ]    offered byte closes its message
//   req_ready   [NREQ]    arbiter accepts requester i's byte this cycle
//   fifo_wrfull           tx FIFO write side is full
//   fifo_data   [8]       byte written to the tx FIFO
//   fifo_wrreq            tx FIFO write strobe
//   busy                  a grant is active
//   grant_id    [IDW]     granted requester, meaningful while busy
// master: requesters + FIFO side. slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_wrfull;
  logic [7:0]        fifo_data;
  logic              fifo_wrreq;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  modport master (
    output req_valid, req_data, req_last, fifo_wrfull,
    input  req_ready, fifo_data, fifo_wrreq, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_wrfull,
    output req_ready, fifo_data, fifo_wrreq, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message-atomic arbiter onto the UART tx FIFO write port
//
// Purpose: shares one tx FIFO write port between NREQ byte-stream requesters.
// A grant is held until the granted requester sends a byte marked last, sends
// MAX_BURST bytes, or offers nothing for IDLE_TIMEOUT cycles.
// Ports:
//   clk   FIFO write-side clock, rising edge
//   rst   synchronous reset, active-high; also gates all outputs low
//   arb   uart_tx_arbiter_if.slave (requester handshakes, FIFO write port,
//         busy, grant_id)
module uart_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64,
  parameter int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
  localparam logic [7:0] IDLE_LIM  = 8'(IDLE_TIMEOUT);

  state_t         state, state_nxt;
  logic [IDW-1:0] grant_q, grant_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt;
  logic [7:0]     burst_cnt, burst_nxt;
  logic [7:0]     idle_cnt, idle_nxt;

  logic           pick_found;
  logic [IDW-1:0] pick_id;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin : rr_search
    logic [IDW-1:0] idx;
    idx        = '0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!pick_found && arb.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
      idle_cnt  <= idle_nxt;
    end
  end

  always_comb begin
    logic release_now;
    release_now    = 1'b0;
    state_nxt      = state;
    grant_nxt      = grant_q;
    rr_nxt         = rr_ptr;
    burst_nxt      = burst_cnt;
    idle_nxt       = idle_cnt;
    arb.req_ready  = '0;
    arb.fifo_wrreq = 1'b0;
    arb.fifo_data  = 8'h00;
    arb.busy       = 1'b0;

    case (state)
      IDLE: begin
        // Arbitrate only; the first byte moves on the following cycle.
        if (pick_found) begin
          grant_nxt = pick_id;
          state_nxt = GRANT;
        end
      end

      GRANT: begin
        arb.busy               = 1'b1;
        arb.req_ready[grant_q] = ~arb.fifo_wrfull;
        arb.fifo_wrreq         = arb.req_valid[grant_q] & ~arb.fifo_wrfull;
        if (arb.fifo_wrreq) begin
          arb.fifo_data = arb.req_data[{grant_q, 3'b000} +: 8];
          burst_nxt     = burst_cnt + 8'd1;
          idle_nxt      = 8'd0;
          if (arb.req_last[grant_q] || (burst_cnt + 8'd1 == BURST_LIM)) begin
            release_now = 1'b1;
          end
        end else if (!arb.req_valid[grant_q]) begin
          idle_nxt = idle_cnt + 8'd1;
          if (idle_cnt + 8'd1 == IDLE_LIM) begin
            release_now = 1'b1;
          end
        end
        // A FIFO-full stall with valid held leaves both counters untouched.

        if (release_now) begin
          state_nxt = IDLE;
          rr_nxt    = IDW'((int'(grant_q) + 1) % NREQ);
          burst_nxt = 8'd0;
          idle_nxt  = 8'd0;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      arb.req_ready  = '0;
      arb.fifo_wrreq = 1'b0;
      arb.fifo_data  = 8'h00;
      arb.busy       = 1'b0;
    end
  end

  assign arb.grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.NREQ(2)) arb ();

  uart_tx_arbiter #(
    .NREQ(2),
    .MAX_BURST(4),
    .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(arb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester byte queues: {last, data}
  logic [8:0] rq0[$];
  logic [8:0] rq1[$];
  logic [1:0] en;
  logic       full;

  // FIFO write log {grant_id, data} and expected log
  logic [8:0] wlog[$];
  logic [8:0] elog[$];

  // Snapshot of DUT outputs taken at the falling edge
  logic       s_busy, s_wr;
  logic [7:0] s_data;
  logic       s_gid;
  logic [1:0] s_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    arb.req_valid   = {en[1] && (rq1.size() > 0), en[0] && (rq0.size() > 0)};
    arb.req_data    = {(rq1.size() > 0) ? rq1[0][7:0] : 8'h00,
                       (rq0.size() > 0) ? rq0[0][7:0] : 8'h00};
    arb.req_last    = {(rq1.size() > 0) ? rq1[0][8] : 1'b0,
                       (rq0.size() > 0) ? rq0[0][8] : 1'b0};
    arb.fifo_wrfull = full;
  endtask

  task automatic tick();
    logic hs0, hs1;
    @(negedge clk);
    hs0     = arb.req_valid[0] & arb.req_ready[0];
    hs1     = arb.req_valid[1] & arb.req_ready[1];
    s_busy  = arb.busy;
    s_wr    = arb.fifo_wrreq;
    s_data  = arb.fifo_data;
    s_gid   = arb.grant_id;
    s_ready = arb.req_ready;
    if (arb.fifo_wrreq) begin
      if (arb.fifo_wrfull) check("wr_while_full", 32'd1, 32'd0);
      wlog.push_back({arb.grant_id, arb.fifo_data});
    end
    @(posedge clk);
    #1;
    if (hs0) void'(rq0.pop_front());
    if (hs1) void'(rq1.pop_front());
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || arb.busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(wlog.size()), 32'(elog.size()));
    for (int i = 0; i < elog.size(); i++) begin
      if (i < wlog.size()) check($sformatf("%s_%0d", tag, i), 32'(wlog[i]), 32'(elog[i]));
    end
    wlog.delete();
    elog.delete();
  endtask

  initial begin
    int n;
    int wr_seen, rdy_seen, idle_seen;

    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    int wr_seen, rdy_seen, idle_seen;
    rst  = 1'b1;
    en   = 2'b11;
    full = 1'b0;

    // T1: reset with every requester valid
    rq0.push_back({1'b1, 8'hAA});
    rq1.push_back({1'b1, 8'hBB});
    drive();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t1_ready_%0d", i), 32'(s_ready), 32'd0);
      check($sformatf("t1_wrreq_%0d", i), 32'(s_wr), 32'd0);
      check($sformatf("t1_busy_%0d", i), 32'(s_busy), 32'd0);
    end
    rst = 1'b0;
    rq0.delete();
    rq1.delete();
    drive();
    tick();
    check("t1_busy_after", 32'(s_busy), 32'd0);
    check("t1_gid_after", 32'(s_gid), 32'd0);
    wlog.delete();

    // T2: one two-byte message from requester 0
    rq0.push_back({1'b0, 8'h31});
    rq0.push_back({1'b1, 8'h32});
    drive();
    tick();
    check("t2_arb_busy", 32'(s_busy), 32'd0);
    check("t2_arb_wr", 32'(s_wr), 32'd0);
    tick();
    check("t2_b0_wr", 32'(s_wr), 32'd1);
    check("t2_b0_data", 32'(s_data), 32'h31);
    check("t2_b0_gid", 32'(s_gid), 32'd0);
    check("t2_b0_ready", 32'(s_ready), 32'b01);
    tick();
    check("t2_b1_wr", 32'(s_wr), 32'd1);
    check("t2_b1_data", 32'(s_data), 32'h32);
    tick();
    check("t2_released", 32'(s_busy), 32'd0);
    check("t2_none_left", 32'(rq0.size()), 32'd0);
    wlog.delete();

    // rr_ptr is now 1: requester 1 wins a tie first
    rq0.push_back({1'b1, 8'h41});
    rq1.push_back({1'b1, 8'h51});
    drive();
    drain("t2rr", 50);
    elog = '{9'h151, 9'h041};
    check_log("t2rr");

    // T3: after reset, alternating single-byte messages
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rq0.push_back({1'b1, 8'h60});
    rq0.push_back({1'b1, 8'h61});
    rq1.push_back({1'b1, 8'h70});
    rq1.push_back({1'b1, 8'h71});
    drive();
    drain("t3", 50);
    elog = '{9'h060, 9'h170, 9'h061, 9'h171};
    check_log("t3");

    // T4: requester 1 streams 10 unterminated bytes, requester 0 waits
    for (int i = 0; i < 10; i++) rq1.push_back({1'b0, 8'(8'h80 + i)});
    drive();
    tick();
    rq0.push_back({1'b1, 8'h90});
    drive();
    drain("t4", 100);
    elog = '{9'h180, 9'h181, 9'h182, 9'h183, 9'h090,
             9'h184, 9'h185, 9'h186, 9'h187, 9'h188, 9'h189};
    check_log("t4");

    // T5: FIFO full for 20 cycles in the middle of a grant
    rq0.push_back({1'b0, 8'hA0});
    rq0.push_back({1'b0, 8'hA1});
    rq0.push_back({1'b0, 8'hA2});
    rq0.push_back({1'b1, 8'hA3});
    drive();
    n = 0;
    while (wlog.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    check("t5_first_two", 32'(wlog.size()), 32'd2);
    full = 1'b1;
    drive();
    wr_seen = 0; rdy_seen = 0; idle_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_wr) wr_seen++;
      if (s_ready != 2'b00) rdy_seen++;
      if (!s_busy) idle_seen++;
    end
    check("t5_wr_while_full", 32'(wr_seen), 32'd0);
    check("t5_ready_while_full", 32'(rdy_seen), 32'd0);
    check("t5_no_release", 32'(idle_seen), 32'd0);
    full = 1'b0;
    drive();
    drain("t5", 50);
    elog = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3};
    check_log("t5");

    // T6: granted requester 1 goes quiet, requester 0 waits for the timeout
    rq1.push_back({1'b0, 8'hB0});
    rq1.push_back({1'b0, 8'hB1});
    rq0.push_back({1'b1, 8'hC0});
    drive();
    n = 0;
    while (wlog.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    check("t6_first", 32'(wlog.size()), 32'd1);
    en[1] = 1'b0;
    drive();
    n = 0;
    while (wlog.size() < 2 && n < 40) begin
      tick();
      n++;
    end
    check("t6_timeout_cycles", 32'(n), 32'd10);
    check("t6_b1_held", 32'(rq1.size()), 32'd1);
    en[1] = 1'b1;
    drive();
    drain("t6", 50);
    elog = '{9'h1B0, 9'h0C0, 9'h1B1};
    check_log("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
